// File: rtl/interrupt_interface.sv
// rtl/interrupt_interface.sv - interrupt synchronizer, mip builder and prioritized request toward commit
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module interrupt_interface #(
  parameter int SYNC_STAGES = 2,
  parameter bit EXT_EDGE    = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         all_intif_int_software_req,
  input  logic                         all_intif_int_timer_req,
  input  logic                         all_intif_int_ext_req,
  input  logic [`REG_DATA_WIDTH-1:0]   csrf_all_mie_data,
  input  logic [`REG_DATA_WIDTH-1:0]   csrf_all_mstatus_data,
  output logic [`REG_DATA_WIDTH-1:0]   intif_csrf_mip_data,
  output logic                         intif_commit_has_interrupt,
  output logic [`REG_DATA_WIDTH-1:0]   intif_commit_mcause_data,
  input  logic                         commit_intif_ack
);

  typedef enum logic [1:0] {IDLE, REQ, BLANK} state_t;

  state_t                       state, state_next;
  logic [SYNC_STAGES-1:0]       sw_sync, tmr_sync, ext_sync;
  logic                         s_sw, s_tmr, s_ext;
  logic                         ext_prev, ext_pend;
  logic                         ext_rise, ext_clr;
  logic                         meip;
  logic [`REG_DATA_WIDTH-1:0]   mip, en;
  logic [`REG_DATA_WIDTH-1:0]   mcause_q, mcause_next;
  logic [3:0]                   code;
  logic                         load_cause;
  logic                         unused_mstatus;

  assign unused_mstatus = ^csrf_all_mstatus_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_sync  <= '0;
      tmr_sync <= '0;
      ext_sync <= '0;
    end else begin
      sw_sync[0]  <= all_intif_int_software_req;
      tmr_sync[0] <= all_intif_int_timer_req;
      ext_sync[0] <= all_intif_int_ext_req;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sync[i]  <= sw_sync[i-1];
        tmr_sync[i] <= tmr_sync[i-1];
        ext_sync[i] <= ext_sync[i-1];
      end
    end
  end

  assign s_sw  = sw_sync[SYNC_STAGES-1];
  assign s_tmr = tmr_sync[SYNC_STAGES-1];
  assign s_ext = ext_sync[SYNC_STAGES-1];

  // Sticky external pending: a new edge coinciding with the ack wins over the clear.
  assign ext_rise = s_ext & ~ext_prev;
  assign ext_clr  = (state == REQ) && commit_intif_ack && (mcause_q[3:0] == 4'd11);

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_prev <= 1'b0;
      ext_pend <= 1'b0;
    end else begin
      ext_prev <= s_ext;
      ext_pend <= ext_rise | (ext_pend & ~ext_clr);
    end
  end

  assign meip = EXT_EDGE ? ext_pend : s_ext;

  always_comb begin
    mip     = '0;
    mip[3]  = s_sw;
    mip[7]  = s_tmr;
    mip[11] = meip;
  end

  assign en = mip & csrf_all_mie_data & {`REG_DATA_WIDTH{csrf_all_mstatus_data[3]}};

  always_comb begin
    code = 4'd0;
    if (en[11])     code = 4'd11;
    else if (en[3]) code = 4'd3;
    else if (en[7]) code = 4'd7;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mcause_q <= '0;
    end else begin
      state <= state_next;
      if (load_cause) mcause_q <= mcause_next;
    end
  end

  always_comb begin
    state_next  = state;
    load_cause  = 1'b0;
    mcause_next = '0;
    mcause_next[`REG_DATA_WIDTH-1] = 1'b1;
    mcause_next[3:0] = code;
    case (state)
      IDLE: begin
        if (|en) begin
          state_next = REQ;
          load_cause = 1'b1;
        end
      end
      REQ: begin
        if (commit_intif_ack)         state_next = BLANK;
        else if (!en[mcause_q[3:0]])  state_next = IDLE;
      end
      // One dead cycle lets the trap-entry mstatus write land before re-evaluation.
      BLANK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign intif_csrf_mip_data        = mip;
  assign intif_commit_has_interrupt = (state == REQ);
  assign intif_commit_mcause_data   = mcause_q;

endmodule
